// File: rtl/lsu_mmio_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_mmio_ctrl_if
// Request/response bus between the core MEM stage and the load-store unit.
//   req_valid_i / req_ready_o   request handshake (accepted when both high)
//   req_we_i                    1 = store, 0 = load
//   req_addr_i                  byte address
//   req_size_i                  00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i              load zero-extend (1) or sign-extend (0)
//   req_wdata_i                 store data, LSB-aligned
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_rdata_o                 extended load data (0 for stores and errors)
//   rsp_err_o                   access error flag
// Modports: master (core side), slave (load-store unit side).
// -----------------------------------------------------------------------------
interface lsu_mmio_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
           req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mmio_ctrl
// Load-store unit between the core MEM stage, a synchronous data RAM and the
// board I/O registers (HEX, LEDR, LEDG, LCD, switches).
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   bus        lsu_mmio_ctrl_if.slave request/response bus
//   io_sw_i    raw switch pins (2-FF synchronised internally)
//   io_hex_o   HEX registers, HEX n at bits [32n+31:32n]
//   io_ledr_o  red LED register
//   io_ledg_o  green LED register
//   io_lcd_o   LCD register
// Byte map: RAM 0x000.., HEX n 0x800+16n, LEDR 0x880, LEDG 0x890, LCD 0x8A0,
// SW 0x900 (read-only). Only word 0 of each 16-byte peripheral window exists.
// Build option: define LSU_MISALIGN_ERR_EN to flag misaligned half/word
// accesses as errors; otherwise the low address bits are ignored (aligned).
// -----------------------------------------------------------------------------
module lsu_mmio_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DMEM_WORDS = 512,
  parameter int NUM_HEX    = 8,
  parameter int SW_W       = 18
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lsu_mmio_ctrl_if.slave       bus,
  input  logic [SW_W-1:0]      io_sw_i,
  output logic [NUM_HEX*32-1:0] io_hex_o,
  output logic [31:0]          io_ledr_o,
  output logic [31:0]          io_ledg_o,
  output logic [31:0]          io_lcd_o
);

  localparam int IDX_W  = $clog2(DMEM_WORDS);
  localparam int WIN_W  = ADDR_W - 4;
  localparam int HEX_IW = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;
  localparam logic [ADDR_W:0]  RAM_BYTES = (ADDR_W+1)'(4 * DMEM_WORDS);
  localparam logic [WIN_W-1:0] HEX_WIN   = WIN_W'('h80);
  localparam logic [WIN_W-1:0] HEX_END   = HEX_WIN + WIN_W'(NUM_HEX);
  localparam logic [WIN_W-1:0] LEDR_WIN  = WIN_W'('h88);
  localparam logic [WIN_W-1:0] LEDG_WIN  = WIN_W'('h89);
  localparam logic [WIN_W-1:0] LCD_WIN   = WIN_W'('h8A);
  localparam logic [WIN_W-1:0] SW_WIN    = WIN_W'('h90);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;

  logic [31:0]       mem [DMEM_WORDS];
  logic [31:0]       ram_rd_p0;
  logic              we_p0, uns_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       hex_q [NUM_HEX];
  logic [31:0]       ledr_q, ledg_q, lcd_q;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [WIN_W-1:0]  win;
  logic [HEX_IW-1:0] hex_n;
  logic [IDX_W-1:0]  ram_idx;
  logic              word0, ram_hit, hex_hit, ledr_hit, ledg_hit, lcd_hit, sw_hit;
  logic              mis, acc_err;
  logic [31:0]       rd_word, st_data;
  logic [3:0]        st_be;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Stage boundary: IDLE -> ACCESS. The RAM read is launched on the accept edge.
  always_ff @(posedge clk_i) begin
    if (bus.req_valid_i && bus.req_ready_o) begin
      we_p0     <= bus.req_we_i;
      addr_p0   <= bus.req_addr_i;
      size_p0   <= bus.req_size_i;
      uns_p0    <= bus.req_unsigned_i;
      wdata_p0  <= bus.req_wdata_i;
      ram_rd_p0 <= mem[bus.req_addr_i[IDX_W+1:2]];
    end
    if (state_q == ACCESS && we_p0 && !acc_err && ram_hit)
      for (int b = 0; b < 4; b++)
        if (st_be[b]) mem[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
  end

  // Decode of the latched request, evaluated during ACCESS
  always_comb begin
    win      = addr_p0[ADDR_W-1:4];
    word0    = (addr_p0[3:2] == 2'b00);
    hex_n    = HEX_IW'(win - HEX_WIN);
    ram_idx  = addr_p0[IDX_W+1:2];
    ram_hit  = ({1'b0, addr_p0} < RAM_BYTES);
    hex_hit  = !ram_hit && word0 && (win >= HEX_WIN) && (win < HEX_END);
    ledr_hit = !ram_hit && word0 && (win == LEDR_WIN);
    ledg_hit = !ram_hit && word0 && (win == LEDG_WIN);
    lcd_hit  = !ram_hit && word0 && (win == LCD_WIN);
    sw_hit   = !ram_hit && word0 && (win == SW_WIN);
`ifdef LSU_MISALIGN_ERR_EN
    mis = (size_p0 == 2'b01 && addr_p0[0]) || (size_p0 == 2'b10 && addr_p0[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    acc_err = (size_p0 == 2'b11) || mis || (we_p0 && sw_hit) ||
              !(ram_hit || hex_hit || ledr_hit || ledg_hit || lcd_hit || sw_hit);
    rd_word = '0;
    if (ram_hit)       rd_word = ram_rd_p0;
    else if (hex_hit)  rd_word = hex_q[hex_n];
    else if (ledr_hit) rd_word = ledr_q;
    else if (ledg_hit) rd_word = ledg_q;
    else if (lcd_hit)  rd_word = lcd_q;
    else if (sw_hit)   rd_word = 32'(sw_sync);
    st_be   = store_be(addr_p0[1:0], size_p0);
    st_data = store_lanes(wdata_p0, size_p0);
  end

  // Stage boundary: ACCESS -> RESP. Stores commit and the response is registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ledr_q      <= '0;
      ledg_q      <= '0;
      lcd_q       <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= '0;
    end else begin
      sw_meta <= io_sw_i;
      sw_sync <= sw_meta;
      if (state_q == ACCESS) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err || we_p0) ? 32'b0
                       : load_extract(rd_word, addr_p0[1:0], size_p0, uns_p0);
        if (we_p0 && !acc_err) begin
          if (hex_hit)  hex_q[hex_n] <= merge_bytes(hex_q[hex_n], st_data, st_be);
          if (ledr_hit) ledr_q <= merge_bytes(ledr_q, st_data, st_be);
          if (ledg_hit) ledg_q <= merge_bytes(ledg_q, st_data, st_be);
          if (lcd_hit)  lcd_q  <= merge_bytes(lcd_q, st_data, st_be);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = hex_q[g];
  end
  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;

endmodule

// File: tb/tb_lsu_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mmio_ctrl
// Directed scenarios followed by randomized traffic, every response and every
// peripheral register compared against a byte-addressed reference model.
// -----------------------------------------------------------------------------
module tb_lsu_mmio_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [17:0]  io_sw_i;
  logic [255:0] io_hex_o;
  logic [31:0]  io_ledr_o, io_ledg_o, io_lcd_o;

  lsu_mmio_ctrl_if #(.ADDR_W(12)) bus ();

  lsu_mmio_ctrl #(.ADDR_W(12), .DMEM_WORDS(512), .NUM_HEX(8), .SW_W(18)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .io_sw_i   (io_sw_i),
    .io_hex_o  (io_hex_o),
    .io_ledr_o (io_ledr_o),
    .io_ledg_o (io_ledg_o),
    .io_lcd_o  (io_lcd_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: byte-addressed RAM and peripheral space, switch value
  logic [7:0]  ram_m [0:2047];
  logic [7:0]  per_m [0:511];
  logic [17:0] sw_m;

  logic [31:0] rd;
  logic        er;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] per_word(input int base);
    int o;
    o = base - 'h800;
    return {per_m[o+3], per_m[o+2], per_m[o+1], per_m[o]};
  endfunction

  function automatic void model_reset_io();
    for (int i = 0; i < 512; i++) per_m[i] = 8'h00;
  endfunction

  function automatic void model_access(input logic we, input logic [11:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int nb, a, region;
    logic [31:0] val;
    logic [7:0]  bt;
    rdata = 32'h0;
    err   = 1'b0;
    if (size == 2'b11) begin err = 1'b1; return; end
    nb = 1 << size;
`ifdef LSU_MISALIGN_ERR_EN
    if (int'(addr) % nb != 0) begin err = 1'b1; return; end
    a = int'(addr);
`else
    a = int'(addr) - (int'(addr) % nb);
`endif
    if (a < 'h800)                                   region = 0;
    else if (a < 'h880 && (a % 16) < 4)              region = 1;
    else if (a >= 'h880 && a < 'h884)                region = 1;
    else if (a >= 'h890 && a < 'h894)                region = 1;
    else if (a >= 'h8A0 && a < 'h8A4)                region = 1;
    else if (a >= 'h900 && a < 'h904)                region = 2;
    else                                             region = -1;
    if (region < 0 || (region == 2 && we)) begin err = 1'b1; return; end
    if (we) begin
      for (int k = 0; k < nb; k++) begin
        bt = wdata[8*k +: 8];
        if (region == 0) ram_m[a+k] = bt;
        else             per_m[a+k-'h800] = bt;
      end
      return;
    end
    val = 32'h0;
    for (int k = 0; k < nb; k++) begin
      if (region == 0)      bt = ram_m[a+k];
      else if (region == 1) bt = per_m[a+k-'h800];
      else                  bt = 8'(32'(sw_m) >> (8*((a+k) % 4)));
      val = val | (32'(bt) << (8*k));
    end
    if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
    rdata = val;
  endfunction

  task automatic check_io();
    for (int n = 0; n < 8; n++) check32("hex", io_hex_o[32*n +: 32], per_word('h800 + 16*n));
    check32("ledr", io_ledr_o, per_word('h880));
    check32("ledg", io_ledg_o, per_word('h890));
    check32("lcd",  io_lcd_o,  per_word('h8A0));
  endtask

  task automatic do_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdo, output logic ero);
    logic [31:0] exp_d;
    logic        exp_e;
    bit          ok;
    int          lat;
    model_access(we, addr, size, uns, wdata, exp_d, exp_e);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = addr;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wdata;
    bus.rsp_ready_i    = (hold == 0);
    rdo = 32'h0;
    ero = 1'b1;
    ok  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus.req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check32("accept_timeout", 32'h0, 32'h1);
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      return;
    end
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      lat++;
      if (bus.rsp_valid_o) begin ok = 1'b1; break; end
    end
    check32("latency", 32'(lat), 32'd2);
    if (!ok) begin bus.rsp_ready_i = 1'b1; return; end
    check_io();
    rdo = bus.rsp_rdata_o;
    ero = bus.rsp_err_o;
    check32("rdata", rdo, exp_d);
    check32("err", 32'(ero), 32'(exp_e));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        check32("hold_rdata", bus.rsp_rdata_o, exp_d);
        check32("hold_err", 32'(bus.rsp_err_o), 32'(exp_e));
        check32("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
        check32("hold_ready", 32'(bus.req_ready_o), 32'd0);
      end
      bus.rsp_ready_i = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [11:0] ra;
    logic [1:0]  rs;
    int          r;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_size_i = 2'b00; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b1;
    io_sw_i = '0;
    sw_m    = '0;
    model_reset_io();
    rst_i = 1'b1;
    wait_cycles(3);
    rst_i = 1'b0;
    @(negedge clk_i);
    check32("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check32("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check32("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    check32("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    check_io();

    for (int w = 0; w < 32; w++) do_req(1'b1, 12'(4*w), 2'b10, 1'b0, $urandom, 0, rd, er);

    do_req(1'b1, 12'h004, 2'b10, 1'b0, 32'h1234_5678, 0, rd, er);
    do_req(1'b0, 12'h004, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("dir_lw", rd, 32'h1234_5678);
    check32("dir_lw_err", 32'(er), 32'd0);
    do_req(1'b1, 12'h005, 2'b00, 1'b0, 32'h80, 0, rd, er);
    do_req(1'b0, 12'h005, 2'b00, 1'b0, 32'h0, 0, rd, er);
    check32("dir_lb", rd, 32'hFFFF_FF80);
    do_req(1'b0, 12'h005, 2'b00, 1'b1, 32'h0, 0, rd, er);
    check32("dir_lbu", rd, 32'h0000_0080);
    do_req(1'b0, 12'h004, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("dir_lw_merged", rd, 32'h1234_8078);

    do_req(1'b1, 12'h830, 2'b10, 1'b0, 32'h3F, 0, rd, er);
    check32("dir_hex3", io_hex_o[127:96], 32'h3F);
    do_req(1'b1, 12'h880, 2'b10, 1'b0, 32'hA5, 0, rd, er);
    check32("dir_ledr", io_ledr_o, 32'hA5);

    io_sw_i = 18'h2AAAA;
    wait_cycles(3);
    sw_m = io_sw_i;
    do_req(1'b0, 12'h900, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("dir_sw", rd, 32'h0002_AAAA);
    do_req(1'b1, 12'h900, 2'b10, 1'b0, 32'hFFFF_FFFF, 0, rd, er);
    check32("dir_sw_store_err", 32'(er), 32'd1);
    do_req(1'b0, 12'h900, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("dir_sw_after", rd, 32'h0002_AAAA);

    do_req(1'b0, 12'h006, 2'b10, 1'b0, 32'h0, 0, rd, er);
`ifdef LSU_MISALIGN_ERR_EN
    check32("dir_mis_err", 32'(er), 32'd1);
    check32("dir_mis_data", rd, 32'h0);
`else
    check32("dir_mis_err", 32'(er), 32'd0);
    check32("dir_mis_data", rd, 32'h1234_8078);
`endif
    do_req(1'b0, 12'hC00, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("dir_unmapped", 32'(er), 32'd1);
    check32("dir_unmapped_data", rd, 32'h0);
    do_req(1'b0, 12'h004, 2'b11, 1'b0, 32'h0, 0, rd, er);
    check32("dir_size_err", 32'(er), 32'd1);

    do_req(1'b0, 12'h004, 2'b10, 1'b0, 32'h0, 5, rd, er);
    check32("dir_bp_data", rd, 32'h1234_8078);

    // Reset in the ACCESS cycle of a store to LEDG
    do_req(1'b1, 12'h890, 2'b10, 1'b0, 32'h55, 0, rd, er);
    check32("dir_ledg_pre", io_ledg_o, 32'h55);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 12'h890;
    bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'h77;
    @(negedge clk_i);
    check32("abort_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    rst_i = 1'b1;
    model_reset_io();
    @(negedge clk_i);
    check32("abort_ledg", io_ledg_o, 32'h0);
    check32("abort_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check32("abort_ledg_after", io_ledg_o, 32'h0);
    check32("abort_rsp_valid_after", 32'(bus.rsp_valid_o), 32'd0);
    check32("abort_ready_after", 32'(bus.req_ready_o), 32'd1);
    wait_cycles(3);
    do_req(1'b0, 12'h004, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check32("ram_kept", rd, 32'h1234_8078);

    for (int it = 0; it < 200; it++) begin
      if (it % 25 == 0) begin
        io_sw_i = 18'($urandom);
        wait_cycles(3);
        sw_m = io_sw_i;
      end
      r = $urandom_range(0, 99);
      if (r < 50)      ra = 12'($urandom_range(0, 127));
      else if (r < 65) ra = 12'('h800 + 16*$urandom_range(0, 7) + $urandom_range(0, 7));
      else if (r < 75) ra = 12'('h880 + 16*$urandom_range(0, 2) + $urandom_range(0, 5));
      else if (r < 85) ra = 12'('h900 + $urandom_range(0, 5));
      else             ra = 12'('hA00 + $urandom_range(0, 'h5FF));
      r  = $urandom_range(0, 9);
      rs = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_req(1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 9) == 0) ? 2 : 0, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
